beta_redirect_ctrl: RTL and testbench
=====================================

# beta_redirect_ctrl

Control-flow redirect controller for the beta core's execute stage. It watches the branch & jump unit's per-instruction result and turns taken branches and jumps into a handshaked PC redirect toward fetch. It squashes wrong-path instructions in IF/ID/EXE for a programmable drain window. A misaligned target becomes a trap request to the exception path instead of a redirect.

## Interface
Parameters:
- DATAWIDTH, 32, PC/address width
- FLUSH_CYCLES, 2, extra cycles flush_o stays high after the redirect is accepted (legal 0..7)

Ports:
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  synchronous, active-high reset
- exe_valid_i  in  1  valid, non-squashed instruction in EXE this cycle
- bju_en_i  in  2  BJU enable field of that instruction: 00 none, 01 branch, 10 JAL, 11 JALR
- bju_taken_i  in  1  BJU branch-taken flag (branches only)
- bju_misalig_i  in  1  BJU misaligned-target flag
- bju_next_pc_i  in  DATAWIDTH  BJU computed next PC
- bju_pc_i  in  DATAWIDTH  PC of the instruction in EXE
- redir_ready_i  in  1  fetch accepts redirect
- exc_ack_i  in  1  exception unit accepts trap
- redir_valid_o  out  1  redirect request to fetch
- redir_pc_o  out  DATAWIDTH  redirect target
- flush_o  out  1  squash IF/ID/EXE contents this cycle
- exc_req_o  out  1  misaligned-target trap request
- exc_epc_o  out  DATAWIDTH  PC of the faulting control instruction
- busy_o  out  1  state != IDLE

## Operation
- Event, evaluated only in IDLE with exe_valid_i=1: redirect = (bju_en_i==01 & bju_taken_i) | bju_en_i==10 | bju_en_i==11. No event for en=00 or a not-taken branch.
- States: IDLE, REDIR, DRAIN, TRAP; 2-bit state register, reset to IDLE.
- IDLE -> TRAP when redirect & bju_misalig_i. Latch bju_pc_i into the epc register.
- IDLE -> REDIR when redirect & !bju_misalig_i. Latch bju_next_pc_i into the target register.
- REDIR: redir_valid_o=1, flush_o=1. The target is held stable. The request must not drop until the cycle redir_ready_i=1 is sampled.
- REDIR exit: when redir_ready_i=1, go to DRAIN and load the drain counter with FLUSH_CYCLES. If FLUSH_CYCLES==0, go straight to IDLE.
- DRAIN: flush_o=1, redir_valid_o=0. The counter decrements each cycle. At count 1 the state goes to IDLE.
- TRAP: exc_req_o=1, flush_o=1, redir_valid_o=0. exc_epc_o is held. Go to IDLE on exc_ack_i=1.
- All events are ignored outside IDLE, including a new one arriving in the same cycle as redir_ready_i or exc_ack_i. Anything in EXE then is wrong-path.
- All outputs are registered. They are decoded from the state and hold registers, with no combinational path from inputs to outputs.
- Counter width is 3 bits. It is never decremented below 0.

## Timing
- Reset: state IDLE. redir_valid_o=0, flush_o=0, exc_req_o=0, busy_o=0, redir_pc_o=0, exc_epc_o=0, counter=0.
- rst_i asserted mid-operation (any state) returns to the reset values on the next edge. A pending request is dropped without a handshake.
- Event sampled at edge N: redir_valid_o / exc_req_o and flush_o are high from cycle N+1.
- Minimum redirect occupancy, with ready already high: 1 REDIR cycle plus FLUSH_CYCLES DRAIN cycles. flush_o is high for 1+FLUSH_CYCLES consecutive cycles.
- The next event is accepted in the first IDLE cycle after DRAIN or TRAP.
- Back-pressure: redir_ready_i low for k cycles keeps REDIR, and therefore flush_o, high for k extra cycles.

## Test plan
- Taken branch: en=01, taken=1, next_pc=0x0000_0100, ready held 1, FLUSH_CYCLES=2 -> next cycle redir_valid_o=1 and redir_pc_o=0x100. flush_o is high for exactly 3 cycles, then IDLE.
- Not-taken branch and en=00 with exe_valid_i=1 -> no redir_valid_o, flush_o or busy_o for 10 cycles.
- JALR with ready low 4 cycles: en=11, next_pc=0x2000_0040 -> redir_valid_o and flush_o are held 5 cycles with the target stable. A second JAL presented during the stall is ignored.
- Misaligned JAL: en=10, misalig=1, pc=0x0000_0080 -> exc_req_o=1 and exc_epc_o=0x80, redir_valid_o stays 0. exc_ack_i after 3 cycles returns to IDLE next edge.
- Reset mid-REDIR with ready low -> the cycle after rst_i all outputs are 0 and busy_o=0. A new taken branch is serviced normally afterward.
- FLUSH_CYCLES=0 with back-to-back taken branches every cycle -> exactly one redirect per 2 cycles (REDIR, IDLE). Intervening events are dropped.

Source files
------------

// File: rtl/beta_redirect_ctrl.sv
// beta_redirect_ctrl: turns taken branches/jumps in EXE into a handshaked fetch
// redirect with a wrong-path flush window, or a trap request on a misaligned target.
module beta_redirect_ctrl #(
   parameter int DATAWIDTH    = 32,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 exe_valid_i,
   input  logic [1:0]           bju_en_i,
   input  logic                 bju_taken_i,
   input  logic                 bju_misalig_i,
   input  logic [DATAWIDTH-1:0] bju_next_pc_i,
   input  logic [DATAWIDTH-1:0] bju_pc_i,
   input  logic                 redir_ready_i,
   input  logic                 exc_ack_i,
   output logic                 redir_valid_o,
   output logic [DATAWIDTH-1:0] redir_pc_o,
   output logic                 flush_o,
   output logic                 exc_req_o,
   output logic [DATAWIDTH-1:0] exc_epc_o,
   output logic                 busy_o
);
   typedef enum logic [1:0] {IDLE, REDIR, DRAIN, TRAP} state_t;
   localparam logic [2:0] FC = 3'(FLUSH_CYCLES);
   state_t     state;
   logic [2:0] cnt;
   logic       redirect;
   assign redirect = exe_valid_i & ((bju_en_i == 2'b01 & bju_taken_i) | bju_en_i[1]);
   // Outputs are flops updated together with the state, never decoded from inputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state         <= IDLE;
         cnt           <= '0;
         redir_valid_o <= 1'b0;
         flush_o       <= 1'b0;
         exc_req_o     <= 1'b0;
         busy_o        <= 1'b0;
         redir_pc_o    <= '0;
         exc_epc_o     <= '0;
      end else begin
         case (state)
            IDLE: if (redirect) begin
               flush_o <= 1'b1;
               busy_o  <= 1'b1;
               if (bju_misalig_i) begin
                  state     <= TRAP;
                  exc_epc_o <= bju_pc_i;
                  exc_req_o <= 1'b1;
               end else begin
                  state         <= REDIR;
                  redir_pc_o    <= bju_next_pc_i;
                  redir_valid_o <= 1'b1;
               end
            end
            REDIR: if (redir_ready_i) begin
               redir_valid_o <= 1'b0;
               if (FC == 3'd0) begin
                  state   <= IDLE;
                  flush_o <= 1'b0;
                  busy_o  <= 1'b0;
               end else begin
                  state <= DRAIN;
                  cnt   <= FC;
               end
            end
            DRAIN: begin
               cnt <= (cnt != 3'd0) ? cnt - 3'd1 : 3'd0;
               if (cnt <= 3'd1) begin
                  state   <= IDLE;
                  flush_o <= 1'b0;
                  busy_o  <= 1'b0;
               end
            end
            TRAP: if (exc_ack_i) begin
               state     <= IDLE;
               exc_req_o <= 1'b0;
               flush_o   <= 1'b0;
               busy_o    <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_beta_redirect_ctrl.sv
// tb_beta_redirect_ctrl: directed stimulus with expected targets, trap PCs and
// flush-burst lengths queued up front and checked by a monitor on handshakes.
module tb_beta_redirect_ctrl;
   logic clk = 0, rst = 1;
   logic exe_valid = 0, exe_valid0 = 0, taken = 0, misalig = 0, ready = 1, ack = 0;
   logic [1:0] en = 0;
   logic [31:0] next_pc = 0, pc = 0;
   logic rv, fl, er, bz, rv0, fl0, er0, bz0;
   logic [31:0] rpc, epc, rpc0, epc0;
   logic [31:0] rq[$], eq[$], rq0[$];
   int fq[$], fq0[$];
   int pass = 0, total = 0, burst = 0, burst0 = 0, hs0 = 0;

   always #5 clk = ~clk;

   beta_redirect_ctrl #(.DATAWIDTH(32), .FLUSH_CYCLES(2)) dut (
      .clk_i(clk), .rst_i(rst), .exe_valid_i(exe_valid), .bju_en_i(en), .bju_taken_i(taken),
      .bju_misalig_i(misalig), .bju_next_pc_i(next_pc), .bju_pc_i(pc), .redir_ready_i(ready),
      .exc_ack_i(ack), .redir_valid_o(rv), .redir_pc_o(rpc), .flush_o(fl), .exc_req_o(er),
      .exc_epc_o(epc), .busy_o(bz));

   beta_redirect_ctrl #(.DATAWIDTH(32), .FLUSH_CYCLES(0)) dut0 (
      .clk_i(clk), .rst_i(rst), .exe_valid_i(exe_valid0), .bju_en_i(en), .bju_taken_i(taken),
      .bju_misalig_i(misalig), .bju_next_pc_i(next_pc), .bju_pc_i(pc), .redir_ready_i(ready),
      .exc_ack_i(ack), .redir_valid_o(rv0), .redir_pc_o(rpc0), .flush_o(fl0), .exc_req_o(er0),
      .exc_epc_o(epc0), .busy_o(bz0));

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      total++;
      if (a === e) pass++;
      else $display("FAIL %s: got %h expected %h", n, a, e);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor: pops expectations whenever a handshake completes or a flush burst ends.
   always @(negedge clk) begin
      if (rst) begin
         burst = 0;
         burst0 = 0;
      end else begin
         if (rv && ready) begin
            if (rq.size() == 0) chk("unexpected_redirect", rpc, 32'hdead_beef);
            else chk("redir_pc", rpc, rq.pop_front());
         end
         if (er && ack) begin
            if (eq.size() == 0) chk("unexpected_trap", epc, 32'hdead_beef);
            else chk("exc_epc", epc, eq.pop_front());
         end
         if (rv0 && ready) begin
            hs0++;
            if (rq0.size() == 0) chk("unexpected_redirect0", rpc0, 32'hdead_beef);
            else chk("redir_pc0", rpc0, rq0.pop_front());
         end
         if (fl) burst++;
         else if (burst > 0) begin
            if (fq.size() == 0) chk("unexpected_flush", burst, 0);
            else chk("flush_len", burst, fq.pop_front());
            burst = 0;
         end
         if (fl0) burst0++;
         else if (burst0 > 0) begin
            if (fq0.size() == 0) chk("unexpected_flush0", burst0, 0);
            else chk("flush_len0", burst0, fq0.pop_front());
            burst0 = 0;
         end
      end
   end

   initial begin
      logic seen, ok;
      step(2);
      rst = 0;
      chk("rst_outputs", {28'd0, rv, fl, er, bz}, 32'd0);
      chk("rst_redir_pc", rpc, 32'd0);
      chk("rst_exc_epc", epc, 32'd0);
      // taken branch, ready high
      exe_valid = 1; en = 2'b01; taken = 1; next_pc = 32'h100;
      rq.push_back(32'h100); fq.push_back(3);
      step(1);
      exe_valid = 0;
      chk("br_valid", rv, 1);
      chk("br_target", rpc, 32'h100);
      step(3);
      chk("br_idle", {fl, bz}, 0);
      // not-taken branch and no-BJU instructions
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         exe_valid = 1; en = (i < 5) ? 2'b01 : 2'b00; taken = 0;
         step(1);
         seen |= rv | fl | bz;
      end
      exe_valid = 0;
      step(1);
      seen |= rv | fl | bz;
      chk("nt_quiet", seen, 0);
      // JALR with 4 stalled cycles; a JAL arrives during the stall
      ready = 0; exe_valid = 1; en = 2'b11; next_pc = 32'h2000_0040;
      rq.push_back(32'h2000_0040); fq.push_back(7);
      step(1);
      en = 2'b10; next_pc = 32'h0000_3000;
      ok = 1;
      for (int j = 0; j < 5; j++) begin
         ok &= rv && fl && (rpc == 32'h2000_0040);
         if (j == 4) ready = 1;
         step(1);
      end
      exe_valid = 0;
      chk("jalr_held", ok, 1);
      chk("jalr_drain_novalid", {rv, fl}, 2'b01);
      step(2);
      chk("jalr_idle", bz, 0);
      // misaligned JAL becomes a trap
      exe_valid = 1; en = 2'b10; misalig = 1; pc = 32'h80; next_pc = 32'h82;
      eq.push_back(32'h80); fq.push_back(3);
      step(1);
      exe_valid = 0; misalig = 0;
      chk("trap_req", {rv, er, fl}, 3'b011);
      chk("trap_epc", epc, 32'h80);
      step(2);
      chk("trap_held", {rv, er}, 2'b01);
      ack = 1;
      step(1);
      ack = 0;
      chk("trap_idle", {er, fl, bz}, 0);
      // reset while stalled in REDIR drops the request
      ready = 0; exe_valid = 1; en = 2'b01; taken = 1; next_pc = 32'h500;
      step(1);
      exe_valid = 0;
      step(1);
      chk("pre_rst_busy", bz, 1);
      rst = 1;
      step(1);
      chk("mid_rst_outputs", {28'd0, rv, fl, er, bz}, 32'd0);
      chk("mid_rst_pc", rpc, 32'd0);
      rst = 0; ready = 1;
      exe_valid = 1; next_pc = 32'h600;
      rq.push_back(32'h600); fq.push_back(3);
      step(1);
      exe_valid = 0;
      chk("post_rst_target", {31'd0, rv}, 1);
      step(3);
      chk("post_rst_idle", bz, 0);
      // FLUSH_CYCLES=0: back-to-back taken branches, every other one accepted
      for (int i = 0; i < 8; i++) begin
         exe_valid0 = 1; en = 2'b01; taken = 1; next_pc = 32'h1000 + 32'(i * 4);
         if (i % 2 == 0) begin
            rq0.push_back(32'h1000 + 32'(i * 4));
            fq0.push_back(1);
         end
         step(1);
      end
      exe_valid0 = 0;
      step(2);
      @(negedge clk);
      #1;
      chk("fc0_redirects", hs0, 4);
      chk("queues_drained", rq.size() + eq.size() + rq0.size() + fq.size() + fq0.size(), 0);
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule
